// File: rtl/framebuffer_writer.sv
// framebuffer_writer: synchronizes the broker's pixel/command strobes and
// streams pixels into framebuffer memory with raster wrap, HOME and CLEAR.
module framebuffer_writer #(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int ADDR_WIDTH  = 17,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  system_clock,
    input  logic                  reset_n,
    input  logic                  pixel_clock,
    input  logic [11:0]           pixel_data,
    input  logic                  command_clock,
    input  logic [7:0]            command_data,
    output logic [ADDR_WIDTH-1:0] fb_address,
    output logic [11:0]           fb_data,
    output logic                  fb_write_enable,
    input  logic                  fb_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    state_t                 state;
    state_t                 nxt_state;
    logic [SYNC_STAGES-1:0] pix_sync;
    logic [SYNC_STAGES-1:0] cmd_sync;
    logic                   pix_hist;
    logic                   cmd_hist;
    logic                   pix_ev;
    logic                   cmd_ev;
    logic [ADDR_WIDTH-1:0]  counter;
    logic [ADDR_WIDTH-1:0]  nxt_counter;
    logic [ADDR_WIDTH-1:0]  nxt_address;
    logic [ADDR_WIDTH-1:0]  base;
    logic [ADDR_WIDTH-1:0]  after_base;
    logic [11:0]            nxt_data;
    logic [11:0]            pend_data;
    logic [11:0]            nxt_pend_data;
    logic [11:0]            issue_data;
    logic                   pend_valid;
    logic                   nxt_pend_valid;
    logic                   clear_req;
    logic                   nxt_clear_req;
    logic                   nxt_we;
    logic                   nxt_busy;
    logic                   nxt_done;
    logic                   nxt_ovf;
    logic                   accept;
    logic                   home;
    logic                   clr;
    logic                   block;
    logic                   issue;
    logic                   start_clear;

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            pix_sync <= '0;
            cmd_sync <= '0;
            pix_hist <= 1'b0;
            cmd_hist <= 1'b0;
        end else begin
            pix_sync <= {pix_sync[SYNC_STAGES-2:0], pixel_clock};
            cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], command_clock};
            pix_hist <= pix_sync[SYNC_STAGES-1];
            cmd_hist <= cmd_sync[SYNC_STAGES-1];
        end
    end

    assign pix_ev = pix_sync[SYNC_STAGES-1] & ~pix_hist;
    assign cmd_ev = cmd_sync[SYNC_STAGES-1] & ~cmd_hist;

    always_comb begin
        nxt_state      = state;
        nxt_counter    = counter;
        nxt_address    = fb_address;
        nxt_data       = fb_data;
        nxt_we         = fb_write_enable;
        nxt_busy       = busy;
        nxt_done       = 1'b0;
        nxt_ovf        = overflow;
        nxt_pend_valid = pend_valid;
        nxt_pend_data  = pend_data;
        nxt_clear_req  = clear_req;
        issue          = 1'b0;
        issue_data     = '0;
        start_clear    = 1'b0;
        accept         = fb_write_enable & fb_ready;
        home           = cmd_ev && state != CLEAR && command_data == 8'h01;
        clr            = cmd_ev && state != CLEAR && command_data == 8'h02;
        block          = clr || clear_req;
        // Command wins over a same-cycle pixel, so HOME retargets it to 0
        base           = home ? '0 : counter;
        after_base     = (base == LAST) ? '0 : base + 1'b1;

        if (home) nxt_counter = '0;
        if (clr) nxt_clear_req = 1'b1;
        if (pix_ev && (block || state == CLEAR)) nxt_ovf = 1'b1;

        unique case (state)
            IDLE: begin
                if (block) begin
                    start_clear = 1'b1;
                end else if (pix_ev) begin
                    issue      = 1'b1;
                    issue_data = pixel_data;
                end
            end
            WRITE: begin
                if (accept) begin
                    nxt_done = (fb_address == LAST);
                    if (pend_valid) begin
                        issue          = 1'b1;
                        issue_data     = pend_data;
                        nxt_pend_valid = pix_ev && !block;
                        nxt_pend_data  = pixel_data;
                    end else if (pix_ev && !block) begin
                        issue      = 1'b1;
                        issue_data = pixel_data;
                    end else if (block) begin
                        start_clear = 1'b1;
                    end else begin
                        nxt_we    = 1'b0;
                        nxt_state = IDLE;
                    end
                end else if (pix_ev && !block) begin
                    if (pend_valid) begin
                        nxt_ovf = 1'b1;
                    end else begin
                        nxt_pend_valid = 1'b1;
                        nxt_pend_data  = pixel_data;
                    end
                end
            end
            CLEAR: begin
                if (accept) begin
                    if (fb_address == LAST) begin
                        nxt_we      = 1'b0;
                        nxt_busy    = 1'b0;
                        nxt_counter = '0;
                        nxt_state   = IDLE;
                    end else begin
                        nxt_address = fb_address + 1'b1;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase

        if (issue) begin
            nxt_state   = WRITE;
            nxt_we      = 1'b1;
            nxt_address = base;
            nxt_data    = issue_data;
            nxt_counter = after_base;
        end
        if (start_clear) begin
            nxt_state     = CLEAR;
            nxt_we        = 1'b1;
            nxt_busy      = 1'b1;
            nxt_address   = '0;
            nxt_data      = '0;
            nxt_clear_req = 1'b0;
        end
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            counter         <= '0;
            fb_address      <= '0;
            fb_data         <= '0;
            fb_write_enable <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            overflow        <= 1'b0;
            pend_valid      <= 1'b0;
            pend_data       <= '0;
            clear_req       <= 1'b0;
        end else begin
            state           <= nxt_state;
            counter         <= nxt_counter;
            fb_address      <= nxt_address;
            fb_data         <= nxt_data;
            fb_write_enable <= nxt_we;
            busy            <= nxt_busy;
            frame_done      <= nxt_done;
            overflow        <= nxt_ovf;
            pend_valid      <= nxt_pend_valid;
            pend_data       <= nxt_pend_data;
            clear_req       <= nxt_clear_req;
        end
    end
endmodule
